mips32_loader: RTL and testbench

MIPS32_LOADER -- requirements
Module: mips32_loader

---
 rtl/mips32_pkg.sv | 25 ++
 rtl/mips32_loader_if.sv | 21 ++
 rtl/mips32_loader.sv | 106 ++++++++++
 tb/tb_mips32_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared loader constants, FSM encoding and the header acceptance rule.
package mips32_pkg;

  localparam int          MEM_DEPTH = 1024;
  localparam int          ADDR_W    = 10;
  localparam logic [15:0] MAGIC     = 16'h4D50;
  localparam int          LEN_W     = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } ld_state_t;

  // Header bits [15:11] are reserved and deliberately not examined.
  function automatic logic hdr_ok(input logic [31:0] hdr, input logic [15:0] magic,
                                  input int depth);
    logic [31:0] n;
    n = 32'(hdr[LEN_W-1:0]);
    return (hdr[31:16] == magic) && (n != 32'd0) && (n <= $unsigned(depth));
  endfunction

endpackage

// File: rtl/mips32_loader_if.sv
// Host word stream plus core-memory write port; master = host/memory side, slave = loader.
interface mips32_loader_if #(
  parameter int ADDR_W = mips32_pkg::ADDR_W
);
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_loader.sv
// Boot loader: header/data/checksum image into core memory, then releases the core.
// One write per accepted data word, one cycle later; s_ready drops once the image is judged.
module mips32_loader #(
  parameter int          MEM_DEPTH = mips32_pkg::MEM_DEPTH,
  parameter int          ADDR_W    = mips32_pkg::ADDR_W,
  parameter logic [15:0] MAGIC     = mips32_pkg::MAGIC
) (
  input  logic            clk1,
  input  logic            rst,
  mips32_loader_if.slave  bus,
  output logic            core_run,
  output logic            busy,
  output logic            done,
  output logic            err
);
  import mips32_pkg::*;

  ld_state_t         r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_idx, w_idx_nxt, r_len, w_len_nxt, w_idx_inc;
  logic [31:0]       r_sum, w_sum_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_acc;

  assign w_acc     = bus.s_valid & r_ready;
  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_sum_nxt   = r_sum;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    unique case (r_state)
      ST_IDLE: if (w_acc) begin
        w_idx_nxt   = '0;
        w_sum_nxt   = '0;
        w_len_nxt   = bus.s_data[LEN_W-1:0];
        w_state_nxt = hdr_ok(bus.s_data, MAGIC, MEM_DEPTH) ? ST_LOAD : ST_ERROR;
      end
      ST_LOAD: if (w_acc) begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_idx[ADDR_W-1:0];
        w_wdata_nxt = bus.s_data;
        w_sum_nxt   = r_sum + bus.s_data;
        w_idx_nxt   = w_idx_inc;
        // Length is bounded by MEM_DEPTH at the header, so the index stops before wrapping.
        if (w_idx_inc == r_len) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: if (w_acc) begin
        w_state_nxt = (bus.s_data == r_sum) ? ST_DONE : ST_ERROR;
      end
      default: ;
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                  (w_state_nxt == ST_CHECK);
    w_busy_nxt  = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_err_nxt   = (w_state_nxt == ST_ERROR);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_sum   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_sum   <= w_sum_nxt;
      r_ready <= w_ready_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.s_ready   = r_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign core_run      = r_done;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_mips32_loader.sv
// Bench for mips32_loader: vector table, corner sequences and random images vs a stream model.
module tb_mips32_loader;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic core_run, busy, done, err;

  always #5 clk1 = ~clk1;

  mips32_loader_if #(.ADDR_W(10)) bus();

  mips32_loader #(.MEM_DEPTH(1024), .ADDR_W(10), .MAGIC(16'h4D50)) dut (
    .clk1     (clk1),
    .rst      (rst),
    .bus      (bus.slave),
    .core_run (core_run),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        dn;
    logic        er;
    logic        run;
    logic        bsy;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] w [6];
    int          nw;
    logic        exp_done;
    logic        exp_err;
    int          exp_wr;
    int          exp_last;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr;
  int last_addr;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (rdy,we,addr,wdata,done,err,run,busy)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    obs_t a;
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = $urandom;
    @(negedge clk1);
    a = {bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, core_run, busy};
    check("reset_state", a, '0);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk1);
  endtask

  // Stream-level model: word 0 is the header, words 1..N are written to address pos-1
  // one cycle after acceptance, word N+1 is judged against the mod-2^32 sum.
  task automatic run_stream(input logic [31:0] w[$], input int gap_pct, input int stop_acc,
                            input int max_cyc, input string tag);
    int          pos = 0;
    int          n = 0;
    int          verdict = 0;
    int          hold = 0;
    int          cyc = 0;
    logic [31:0] sum = 0;
    logic [31:0] d;
    logic        ewe = 1'b0;
    logic [9:0]  eaddr = '0;
    logic [31:0] edata = '0;
    logic        v, erdy;
    obs_t        a, e;
    n_wr = 0;
    last_addr = -1;
    forever begin
      erdy = (verdict == 0);
      e = {erdy, ewe, ewe ? eaddr : 10'd0, ewe ? edata : 32'd0,
           verdict == 1, verdict == 2, verdict == 1, erdy && pos > 0};
      a = {bus.s_ready, bus.mem_we, ewe ? bus.mem_addr : 10'd0, ewe ? bus.mem_wdata : 32'd0,
           done, err, core_run, busy};
      check(tag, a, e);
      if (bus.mem_we === 1'b1) begin
        n_wr++;
        last_addr = int'(bus.mem_addr);
      end
      if (verdict != 0) hold++;
      if (hold > 3 || (stop_acc >= 0 && pos >= stop_acc)) break;
      if (cyc >= max_cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: no decision after %0d cycles, %0d words accepted", tag, cyc, pos);
        break;
      end
      cyc++;
      v = ($urandom_range(99) >= gap_pct);
      d = (v && pos < w.size()) ? w[pos] : $urandom;
      bus.s_valid = v;
      bus.s_data  = d;
      ewe = 1'b0;
      if (v && erdy) begin
        if (pos == 0) begin
          n = int'(d[10:0]);
          sum = 0;
          if (d[31:16] != 16'h4D50 || n < 1 || n > 1024) verdict = 2;
        end else if (pos <= n) begin
          ewe   = 1'b1;
          eaddr = 10'(pos - 1);
          edata = d;
          sum   = sum + d;
        end else begin
          verdict = (d == sum) ? 1 : 2;
        end
        pos++;
      end
      @(negedge clk1);
    end
    bus.s_valid = 1'b0;
  endtask

  function automatic vec_t mk(input string nm, input logic [31:0] a, b, c, d, e, input int nw,
                              input logic dn, input logic er, input int nwr, input int last);
    vec_t t;
    t.name = nm;
    t.w[0] = a; t.w[1] = b; t.w[2] = c; t.w[3] = d; t.w[4] = e; t.w[5] = 32'd0;
    t.nw = nw;
    t.exp_done = dn;
    t.exp_err = er;
    t.exp_wr = nwr;
    t.exp_last = last;
    return t;
  endfunction

  vec_t tbl [7];

  initial begin
    logic [31:0] q[$];
    logic [31:0] s, x;
    int          nn;
    logic        bad_magic, bad_sum;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    tbl[0] = mk("img3",     32'h4D50_0003, 5, 7, 9, 21, 5, 1'b1, 1'b0, 3, 2);
    tbl[1] = mk("badtag",   32'h1234_0002, 1, 2, 3, 0,  4, 1'b0, 1'b1, 0, -1);
    tbl[2] = mk("modsum",   32'h4D50_0002, 32'hFFFF_FFFF, 2, 1, 0, 4, 1'b1, 1'b0, 2, 1);
    tbl[3] = mk("badsum",   32'h4D50_0002, 32'hFFFF_FFFF, 2, 2, 0, 4, 1'b0, 1'b1, 2, 1);
    tbl[4] = mk("n0",       32'h4D50_0000, 4, 4, 0, 0,  3, 1'b0, 1'b1, 0, -1);
    tbl[5] = mk("n1025",    32'h4D50_0401, 4, 4, 0, 0,  3, 1'b0, 1'b1, 0, -1);
    tbl[6] = mk("rsvdbits", 32'h4D50_F801, 32'h0000_00AB, 32'h0000_00AB, 0, 0, 3, 1'b1, 1'b0, 1, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      q = {};
      for (int j = 0; j < tbl[i].nw; j++) q.push_back(tbl[i].w[j]);
      run_stream(q, (i < 3) ? 0 : 25, -1, 200, tbl[i].name);
      check_int({tbl[i].name, "_done"}, int'(done), int'(tbl[i].exp_done));
      check_int({tbl[i].name, "_err"}, int'(err), int'(tbl[i].exp_err));
      check_int({tbl[i].name, "_writes"}, n_wr, tbl[i].exp_wr);
      check_int({tbl[i].name, "_last_addr"}, last_addr, tbl[i].exp_last);
    end

    // Full-depth image with random valid gaps.
    do_reset();
    q = {32'h4D50_0400};
    s = 0;
    for (int j = 0; j < 1024; j++) begin
      x = $urandom;
      q.push_back(x);
      s = s + x;
    end
    q.push_back(s);
    run_stream(q, 30, -1, 4000, "n1024");
    check_int("n1024_writes", n_wr, 1024);
    check_int("n1024_last_addr", last_addr, 1023);
    check_int("n1024_done", int'(done), 1);

    // Reset after two of four data words, then a fresh one-word image.
    do_reset();
    q = {32'h4D50_0004, 32'd11, 32'd22, 32'd33, 32'd44, 32'd110};
    run_stream(q, 0, 3, 50, "abort");
    do_reset();
    q = {32'h4D50_0001, 32'hCAFE_0001, 32'hCAFE_0001};
    run_stream(q, 25, -1, 100, "fresh");
    check_int("fresh_done", int'(done), 1);
    check_int("fresh_writes", n_wr, 1);
    check_int("fresh_last_addr", last_addr, 0);

    // Random images, some with a corrupted tag or checksum.
    for (int r = 0; r < 20; r++) begin
      nn = int'($urandom_range(12, 1));
      bad_magic = ($urandom_range(99) < 15);
      bad_sum   = ($urandom_range(99) < 30);
      x = {bad_magic ? 16'h4C50 : 16'h4D50, 5'($urandom), 11'(nn)};
      q = {x};
      s = 0;
      for (int j = 0; j < nn; j++) begin
        x = $urandom;
        q.push_back(x);
        s = s + x;
      end
      q.push_back(bad_sum ? s ^ 32'h0000_0100 : s);
      do_reset();
      run_stream(q, 35, -1, 300, "rand");
      check_int("rand_done", int'(done), int'(!bad_magic && !bad_sum));
      check_int("rand_err", int'(err), int'(bad_magic || bad_sum));
      check_int("rand_writes", n_wr, bad_magic ? 0 : nn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
